// File: rtl/forwarder_arbiter.sv
// Round-robin arbiter that lets N_BUFS packet buffers share one forwarder.
// The granted buffer's read port, length and ready are muxed to the forwarder.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   buf_ready/len/rd_data per-buffer packet status, length, read data
//   buf_rd_addr/rd_en     per-buffer read port, driven only for the grant
//   buf_done              per-buffer done pulse
//   fwd_rd_addr/rd_en     forwarder read request
//   fwd_done              forwarder finished the current packet
//   fwd_rd_data/ready/len muxed data, ready and length to the forwarder
//   grant_valid/grant_idx current ownership
//   err_stray_done        sticky flag: fwd_done arrived with no grant
module forwarder_arbiter #(
    parameter int N_BUFS     = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 9,
    parameter int PLEN_WIDTH = ADDR_WIDTH + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_BUFS-1:0]            buf_ready,
    input  logic [N_BUFS*PLEN_WIDTH-1:0] buf_len,
    input  logic [N_BUFS*DATA_WIDTH-1:0] buf_rd_data,
    output logic [N_BUFS*ADDR_WIDTH-1:0] buf_rd_addr,
    output logic [N_BUFS-1:0]            buf_rd_en,
    output logic [N_BUFS-1:0]            buf_done,
    input  logic [ADDR_WIDTH-1:0]        fwd_rd_addr,
    input  logic                         fwd_rd_en,
    input  logic                         fwd_done,
    output logic [DATA_WIDTH-1:0]        fwd_rd_data,
    output logic                         fwd_ready,
    output logic [PLEN_WIDTH-1:0]        fwd_len,
    output logic                         grant_valid,
    output logic [$clog2(N_BUFS)-1:0]    grant_idx,
    output logic                         err_stray_done
);

    localparam int IDX_W = $clog2(N_BUFS);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        GAP
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand_idx;
    logic             any_ready;
    logic             busy;
    int               cand;

    // Scan starting just after the last grant so every buffer gets a turn.
    always_comb begin
        pick      = '0;
        any_ready = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= N_BUFS; k++) begin
            cand     = (int'(last) + k) % N_BUFS;
            cand_idx = IDX_W'(cand);
            if (!any_ready && buf_ready[cand_idx]) begin
                any_ready = 1'b1;
                pick      = cand_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            sel            <= '0;
            last           <= IDX_W'(N_BUFS - 1);
            err_stray_done <= 1'b0;
        end else begin
            if (fwd_done && state != BUSY)
                err_stray_done <= 1'b1;
            case (state)
                IDLE: begin
                    if (any_ready) begin
                        sel   <= pick;
                        last  <= pick;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (fwd_done)
                        state <= GAP;
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == BUSY);

    // sel is frozen through GAP so the last read still returns to the forwarder.
    always_comb begin
        buf_rd_addr = '0;
        buf_rd_en   = '0;
        buf_done    = '0;
        buf_rd_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH] = fwd_rd_addr;
        if (busy) begin
            buf_rd_en[sel] = fwd_rd_en;
            buf_done[sel]  = fwd_done && !rst;
        end
    end

    assign fwd_ready   = busy && buf_ready[sel];
    assign fwd_len     = busy ? buf_len[int'(sel)*PLEN_WIDTH +: PLEN_WIDTH] : '0;
    assign fwd_rd_data = buf_rd_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
    assign grant_valid = (state != IDLE);
    assign grant_idx   = sel;

endmodule

// File: tb/tb_forwarder_arbiter.sv
// Directed bench for forwarder_arbiter.
// Each task drives one scenario and checks outputs inline.
module tb_forwarder_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   buf_ready;
    logic [39:0]  buf_len;
    logic [255:0] buf_rd_data;
    logic [35:0]  buf_rd_addr;
    logic [3:0]   buf_rd_en;
    logic [3:0]   buf_done;
    logic [8:0]   fwd_rd_addr;
    logic         fwd_rd_en;
    logic         fwd_done;
    logic [63:0]  fwd_rd_data;
    logic         fwd_ready;
    logic [9:0]   fwd_len;
    logic         grant_valid;
    logic [1:0]   grant_idx;
    logic         err_stray_done;

    int total;
    int bad;

    forwarder_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .buf_ready      (buf_ready),
        .buf_len        (buf_len),
        .buf_rd_data    (buf_rd_data),
        .buf_rd_addr    (buf_rd_addr),
        .buf_rd_en      (buf_rd_en),
        .buf_done       (buf_done),
        .fwd_rd_addr    (fwd_rd_addr),
        .fwd_rd_en      (fwd_rd_en),
        .fwd_done       (fwd_done),
        .fwd_rd_data    (fwd_rd_data),
        .fwd_ready      (fwd_ready),
        .fwd_len        (fwd_len),
        .grant_valid    (grant_valid),
        .grant_idx      (grant_idx),
        .err_stray_done (err_stray_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        buf_ready = 4'b0000;
        fwd_done  = 1'b0;
        fwd_rd_en = 1'b0;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        fwd_rd_addr = 9'd5;
        do_reset();
        total++;
        if (grant_valid !== 1'b0 || fwd_ready !== 1'b0 || fwd_len !== 10'd0) begin
            bad++;
            $display("FAIL reset_ctrl got gv=%b rdy=%b len=%0d exp 0 0 0",
                     grant_valid, fwd_ready, fwd_len);
        end
        total++;
        if (buf_rd_en !== 4'b0 || buf_done !== 4'b0 || err_stray_done !== 1'b0
            || grant_idx !== 2'd0) begin
            bad++;
            $display("FAIL reset_bufs got en=%b done=%b err=%b idx=%0d exp 0 0 0 0",
                     buf_rd_en, buf_done, err_stray_done, grant_idx);
        end
        total++;
        if (buf_rd_addr !== 36'd5 || fwd_rd_data !== 64'hC0DE_0000_0000_00D0) begin
            bad++;
            $display("FAIL reset_mux got addr=%h data=%h exp 5 c0de0000000000d0",
                     buf_rd_addr, fwd_rd_data);
        end
    endtask

    task automatic test_single();
        do_reset();
        buf_ready = 4'b0100;
        step();
        total++;
        if (grant_idx !== 2'd2 || fwd_ready !== 1'b1 || fwd_len !== 10'd16) begin
            bad++;
            $display("FAIL single_grant got idx=%0d rdy=%b len=%0d exp 2 1 16",
                     grant_idx, fwd_ready, fwd_len);
        end
        fwd_rd_en   = 1'b1;
        fwd_rd_addr = 9'd3;
        #1;
        total++;
        if (buf_rd_en !== 4'b0100 || buf_rd_addr !== 36'h0000C0000) begin
            bad++;
            $display("FAIL single_rd got en=%b addr=%h exp 0100 0000c0000",
                     buf_rd_en, buf_rd_addr);
        end
        fwd_rd_en = 1'b0;
        fwd_done  = 1'b1;
        #1;
        total++;
        if (buf_done !== 4'b0100) begin
            bad++;
            $display("FAIL single_done got %b exp 0100", buf_done);
        end
        step();
        fwd_done  = 1'b0;
        buf_ready = 4'b0000;
        #1;
        total++;
        if (grant_valid !== 1'b1 || fwd_ready !== 1'b0 || buf_done !== 4'b0) begin
            bad++;
            $display("FAIL single_gap got gv=%b rdy=%b done=%b exp 1 0 0000",
                     grant_valid, fwd_ready, buf_done);
        end
        step();
        total++;
        if (grant_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_idle got gv=%b exp 0", grant_valid);
        end
    endtask

    task automatic test_rotate();
        logic [1:0] exp_order [5];
        logic [1:0] e;
        exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        buf_ready = 4'b1111;
        step();
        for (int p = 0; p < 5; p++) begin
            e = exp_order[p];
            fwd_done = 1'b1;
            #1;
            total++;
            if (grant_idx !== e || fwd_ready !== 1'b1 || buf_done !== (4'b0001 << e)) begin
                bad++;
                $display("FAIL rotate_%0d got idx=%0d rdy=%b done=%b exp idx=%0d",
                         p, grant_idx, fwd_ready, buf_done, e);
            end
            step();
            fwd_done = 1'b0;
            step();
            step();
        end
    endtask

    task automatic test_gap_data();
        do_reset();
        buf_ready = 4'b0010;
        step();
        fwd_rd_en   = 1'b1;
        fwd_rd_addr = 9'd7;
        fwd_done    = 1'b1;
        #1;
        total++;
        if (buf_rd_en !== 4'b0010 || buf_rd_addr !== 36'h000000E00
            || buf_done !== 4'b0010) begin
            bad++;
            $display("FAIL gap_last_rd got en=%b addr=%h done=%b exp 0010 000000e00 0010",
                     buf_rd_en, buf_rd_addr, buf_done);
        end
        step();
        fwd_rd_en = 1'b0;
        fwd_done  = 1'b0;
        buf_rd_data[64 +: 64] = 64'hDEAD_BEEF_0000_0007;
        #1;
        total++;
        if (fwd_rd_data !== 64'hDEAD_BEEF_0000_0007 || grant_idx !== 2'd1
            || fwd_ready !== 1'b0) begin
            bad++;
            $display("FAIL gap_data got data=%h idx=%0d rdy=%b exp deadbeef00000007 1 0",
                     fwd_rd_data, grant_idx, fwd_ready);
        end
        step();
        total++;
        if (fwd_ready !== 1'b0) begin
            bad++;
            $display("FAIL gap_spacing_d2 got rdy=%b exp 0", fwd_ready);
        end
        step();
        total++;
        if (fwd_ready !== 1'b1 || grant_idx !== 2'd1) begin
            bad++;
            $display("FAIL gap_spacing_d3 got rdy=%b idx=%0d exp 1 1",
                     fwd_ready, grant_idx);
        end
        buf_rd_data[64 +: 64] = 64'hC0DE_0000_0000_00D1;
    endtask

    task automatic test_stray();
        do_reset();
        fwd_done = 1'b1;
        #1;
        total++;
        if (buf_done !== 4'b0 || grant_valid !== 1'b0) begin
            bad++;
            $display("FAIL stray_nodone got done=%b gv=%b exp 0000 0",
                     buf_done, grant_valid);
        end
        step();
        fwd_done = 1'b0;
        step();
        step();
        step();
        total++;
        if (err_stray_done !== 1'b1) begin
            bad++;
            $display("FAIL stray_sticky got %b exp 1", err_stray_done);
        end
        do_reset();
        total++;
        if (err_stray_done !== 1'b0) begin
            bad++;
            $display("FAIL stray_clear got %b exp 0", err_stray_done);
        end
    endtask

    task automatic test_rst_busy();
        do_reset();
        buf_ready = 4'b1000;
        step();
        total++;
        if (grant_idx !== 2'd3 || fwd_ready !== 1'b1) begin
            bad++;
            $display("FAIL rstb_grant got idx=%0d rdy=%b exp 3 1", grant_idx, fwd_ready);
        end
        step();
        rst = 1'b1;
        #1;
        total++;
        if (buf_done !== 4'b0) begin
            bad++;
            $display("FAIL rstb_nodone got %b exp 0000", buf_done);
        end
        step();
        rst = 1'b0;
        #1;
        total++;
        if (grant_valid !== 1'b0 || fwd_ready !== 1'b0 || buf_done !== 4'b0) begin
            bad++;
            $display("FAIL rstb_idle got gv=%b rdy=%b done=%b exp 0 0 0000",
                     grant_valid, fwd_ready, buf_done);
        end
        step();
        total++;
        if (grant_valid !== 1'b1 || grant_idx !== 2'd3 || fwd_ready !== 1'b1) begin
            bad++;
            $display("FAIL rstb_regrant got gv=%b idx=%0d rdy=%b exp 1 3 1",
                     grant_valid, grant_idx, fwd_ready);
        end
        do_reset();
        buf_ready = 4'b1010;
        step();
        total++;
        if (grant_idx !== 2'd1) begin
            bad++;
            $display("FAIL rstb_prio got idx=%0d exp 1", grant_idx);
        end
    endtask

    task automatic test_stall();
        do_reset();
        buf_ready = 4'b0001;
        step();
        for (int c = 0; c < 3; c++) begin
            buf_ready = 4'b0100;
            #1;
            total++;
            if (fwd_ready !== 1'b0 || grant_idx !== 2'd0 || grant_valid !== 1'b1) begin
                bad++;
                $display("FAIL stall_%0d got rdy=%b idx=%0d gv=%b exp 0 0 1",
                         c, fwd_ready, grant_idx, grant_valid);
            end
            step();
        end
        buf_ready = 4'b0101;
        #1;
        total++;
        if (fwd_ready !== 1'b1 || grant_idx !== 2'd0 || fwd_len !== 10'd5) begin
            bad++;
            $display("FAIL stall_resume got rdy=%b idx=%0d len=%0d exp 1 0 5",
                     fwd_ready, grant_idx, fwd_len);
        end
        fwd_done = 1'b1;
        #1;
        total++;
        if (buf_done !== 4'b0001) begin
            bad++;
            $display("FAIL stall_done got %b exp 0001", buf_done);
        end
        step();
        fwd_done = 1'b0;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b0;
        buf_ready   = 4'b0;
        fwd_rd_addr = 9'd0;
        fwd_rd_en   = 1'b0;
        fwd_done    = 1'b0;
        buf_len     = {10'd100, 10'd16, 10'd33, 10'd5};
        buf_rd_data = {64'hC0DE_0000_0000_00D3, 64'hC0DE_0000_0000_00D2,
                       64'hC0DE_0000_0000_00D1, 64'hC0DE_0000_0000_00D0};
        test_reset();
        test_single();
        test_rotate();
        test_gap_data();
        test_stray();
        test_rst_busy();
        test_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/forwarder_arbiter.md
FORWARDER_ARBITER -- requirements
Module: forwarder_arbiter

Interface
REQ-001 SHALL have parameters: N_BUFS=4, number of packet buffers sharing one forwarder; DATA_WIDTH=64, flit width; ADDR_WIDTH=9, buffer address width; PLEN_WIDTH=ADDR_WIDTH+1, packet length width.
REQ-002 SHALL have ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- buf_ready  in  N_BUFS  per-buffer "packet ready for forwarder".
- buf_len  in  N_BUFS*PLEN_WIDTH  per-buffer packet length; slice i at [i*PLEN_WIDTH +: PLEN_WIDTH].
- buf_rd_data  in  N_BUFS*DATA_WIDTH  per-buffer read data, 1-cycle read latency.
- buf_rd_addr  out  N_BUFS*ADDR_WIDTH  per-buffer read address.
- buf_rd_en  out  N_BUFS  per-buffer read enable.
- buf_done  out  N_BUFS  per-buffer done, 1-cycle pulse.
- fwd_rd_addr  in  ADDR_WIDTH  forwarder read address.
- fwd_rd_en  in  1  forwarder read enable.
- fwd_done  in  1  forwarder done pulse.
- fwd_rd_data  out  DATA_WIDTH  read data to forwarder.
- fwd_ready  out  1  ready_for_forwarder to forwarder.
- fwd_len  out  PLEN_WIDTH  length to forwarder.
- grant_valid  out  1  a buffer is currently owned.
- grant_idx  out  clog2(N_BUFS)  owning buffer index.
- err_stray_done  out  1  sticky: fwd_done seen with no grant.

Function
REQ-003 SHALL have FSM states IDLE, BUSY, GAP; state, sel (grant index) and last (last granted index) registered.
REQ-004 IDLE: if any buf_ready bit set, SHALL register sel = first set index scanning last+1, last+2, ... mod N_BUFS, set last = sel, go to BUSY next cycle; else stay IDLE.
REQ-005 Latency: buf_ready[i] rising at cycle t in IDLE SHALL give fwd_ready=1 at cycle t+1.
REQ-006 BUSY: fwd_ready SHALL equal buf_ready[sel]; fwd_len SHALL equal buf_len slice sel; in all other states fwd_ready=0 and fwd_len=0.
REQ-007 buf_rd_addr slice i SHALL equal fwd_rd_addr when i==sel, else 0, in every state.
REQ-008 buf_rd_en[i] SHALL equal fwd_rd_en && state==BUSY && i==sel; non-granted buffers never see rd_en.
REQ-009 fwd_rd_data SHALL equal buf_rd_data slice sel combinationally; sel SHALL stay constant in BUSY and GAP so data read in the final BUSY cycle returns correctly in GAP.
REQ-010 BUSY with fwd_done=1: buf_done[sel] SHALL pulse that same cycle; FSM SHALL go to GAP. Other buf_done bits 0.
REQ-011 GAP SHALL last exactly one cycle, then IDLE; gives buffers one cycle to drop buf_ready and covers the forwarder's registered-ready refill.
REQ-012 Minimum spacing: done pulse at cycle d -> earliest next fwd_ready=1 at cycle d+3.
REQ-013 fwd_done when state!=BUSY SHALL be ignored (no buf_done pulse) and SHALL set err_stray_done; only rst clears it.
REQ-014 grant_valid SHALL be 1 in BUSY and GAP; grant_idx SHALL equal sel.
REQ-015 buf_ready[sel] falling in BUSY without fwd_done SHALL NOT release the grant; fwd_ready drops and the FSM waits in BUSY.
REQ-016 Changes to buf_ready of non-granted buffers during BUSY/GAP SHALL have no effect until the next IDLE evaluation.
REQ-017 With all N_BUFS ready continuously, grants SHALL rotate 0,1,2,3,0,... with no buffer starved.

Reset
REQ-018 rst=1 SHALL force, on the next edge: state=IDLE, sel=0, last=N_BUFS-1 (buffer 0 highest priority first), err_stray_done=0.
REQ-019 While in IDLE after reset, all outputs SHALL be 0 except fwd_rd_data/buf_rd_addr, which follow the REQ-007/009 mux with sel=0.
REQ-020 rst during BUSY SHALL abort the grant without pulsing buf_done; the buffer keeps its packet and is re-arbitrated.

Verification
REQ-021 Reset, then buf_ready=4'b0100, buf_len slice2=16 -> cycle after: grant_idx=2, fwd_ready=1, fwd_len=16; rd_en only on buf_rd_en[2].
REQ-022 All buf_ready=4'b1111, forwarder completes 5 packets -> grant order 0,1,2,3,0; each done pulse on matching buf_done bit only.
REQ-023 Buffer 1 granted, fwd_rd_en at final BUSY cycle with addr=7, fwd_done same cycle -> buf_rd_data slice1 returned on fwd_rd_data in GAP; next fwd_ready no earlier than done+3.
REQ-024 fwd_done pulsed in IDLE -> no buf_done, err_stray_done=1 and held until rst.
REQ-025 Grant on buffer 3, rst asserted mid-packet with buf_ready=4'b1000 held -> state IDLE, no buf_done[3]; after rst release buffer 0... priority order restarts, buffer 3 re-granted one cycle after IDLE.
REQ-026 buf_ready[sel] dropped for 3 cycles in BUSY -> fwd_ready=0 those cycles, grant_idx unchanged, no other buffer granted.
